// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data wins by default; a saturating streak counter eventually forces a fetch grant.
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        I_REQ,
   input  logic [31:0] I_ADDR,
   input  logic        D_REQ,
   input  logic        D_WRITE,
   input  logic [31:0] D_ADDR,
   input  logic [31:0] D_WDATA,
   input  logic [31:0] MEM_RDATA,
   input  logic        MEM_BUSYWAIT,
   output logic        SELECT,
   output logic        MEM_READ,
   output logic        MEM_WRITE,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_WDATA,
   output logic        I_BUSYWAIT,
   output logic        D_BUSYWAIT,
   output logic [31:0] I_RDATA,
   output logic [31:0] D_RDATA
);

   localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);
   localparam int         SIDE_I = 0;
   localparam int         SIDE_D = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        streak_q, streak_d;
   logic [3:0]        streak_inc;
   logic [1:0]        req;
   logic [1:0]        done;
   logic [1:0]        eligible;
   logic [1:0]        complete;
   logic [1:0]        capture;
   logic [1:0][31:0]  rdata;

   assign req        = {D_REQ, I_REQ};
   assign eligible   = req & ~done;
   assign streak_inc = (streak_q < LIMIT) ? streak_q + 4'd1 : LIMIT;
   // A store completes without touching the load data register.
   assign capture    = {complete[SIDE_D] & ~D_WRITE, complete[SIDE_I]};

   // Per-requester done pulse and read-data register.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : side_g
         logic        done_q, done_d;
         logic [31:0] rdata_q, rdata_d;

         always_comb begin
            done_d  = complete[gi];
            rdata_d = capture[gi] ? MEM_RDATA : rdata_q;
         end

         always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
               done_q  <= 1'b0;
               rdata_q <= '0;
            end else begin
               done_q  <= done_d;
               rdata_q <= rdata_d;
            end
         end

         assign done[gi]  = done_q;
         assign rdata[gi] = rdata_q;
      end
   endgenerate

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= IDLE;
         streak_q <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
      end
   end

   // Arbitration only happens from IDLE, so every grant is followed by a bubble.
   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      complete = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (eligible[SIDE_D] && (!eligible[SIDE_I] || (streak_q < LIMIT))) begin
               state_d  = GRANT_D;
               streak_d = I_REQ ? streak_inc : 4'd0;
            end else if (eligible[SIDE_I]) begin
               state_d  = GRANT_I;
               streak_d = 4'd0;
            end
         end
         GRANT_I: begin
            if (!MEM_BUSYWAIT) begin
               state_d          = IDLE;
               complete[SIDE_I] = 1'b1;
            end
         end
         GRANT_D: begin
            if (!MEM_BUSYWAIT) begin
               state_d          = IDLE;
               complete[SIDE_D] = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      SELECT    = 1'b0;
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      MEM_ADDR  = '0;
      MEM_WDATA = '0;
      unique case (state_q)
         GRANT_I: begin
            MEM_READ = 1'b1;
            MEM_ADDR = I_ADDR;
         end
         GRANT_D: begin
            SELECT    = 1'b1;
            MEM_READ  = ~D_WRITE;
            MEM_WRITE = D_WRITE;
            MEM_ADDR  = D_ADDR;
            MEM_WDATA = D_WDATA;
         end
         default: ;
      endcase
   end

   assign I_BUSYWAIT = I_REQ & ~done[SIDE_I];
   assign D_BUSYWAIT = D_REQ & ~done[SIDE_D];
   assign I_RDATA    = rdata[SIDE_I];
   assign D_RDATA    = rdata[SIDE_D];

endmodule
